mem_ctrl: RTL



---
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-simulator initiator, one outstanding transaction at a time,
// with an 8-byte line buffer that serves sequential instruction fetches locally.
module mem_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic        err_o,
  output logic        ms_if_req_o,
  output logic [31:0] ms_if_addr_o,
  output logic        ms_mem_req_o,
  output logic [31:0] ms_mem_addr_o,
  output logic        ms_write_o,
  output logic [31:0] ms_write_data_o,
  output logic [3:0]  ms_write_mask_o,
  input  logic        if_ms_rep_i,
  input  logic [63:0] if_ms_rep_data_i,
  input  logic        mem_ms_rep_i,
  input  logic [63:0] mem_ms_rep_data_i
);
  typedef enum logic [2:0] {IDLE, WAIT_IF, WAIT_MEM, WRITE, ACK} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [28:0] tag_q, tag_d, buf_tag_q, buf_tag_d;
  logic hi_q, hi_d, buf_vld_q, buf_vld_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, err_q, err_d;
  logic [31:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic ms_if_req_q, ms_if_req_d, ms_mem_req_q, ms_mem_req_d, ms_write_q, ms_write_d;
  logic [31:0] ms_if_addr_q, ms_if_addr_d, ms_mem_addr_q, ms_mem_addr_d;
  logic [31:0] ms_write_data_q, ms_write_data_d;
  logic [3:0] ms_write_mask_q, ms_write_mask_d;
  logic hit, timed_out;
  assign hit = buf_vld_q && (if_addr_i[31:3] == buf_tag_q);
  assign timed_out = cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    tag_d = tag_q;
    hi_d = hi_q;
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    buf_data_d = buf_data_q;
    if_ack_d = 1'b0;
    if_data_d = '0;
    mem_ack_d = 1'b0;
    mem_rdata_d = '0;
    err_d = 1'b0;
    ms_if_req_d = 1'b0;
    ms_if_addr_d = '0;
    ms_mem_req_d = 1'b0;
    ms_mem_addr_d = '0;
    ms_write_d = 1'b0;
    ms_write_data_d = '0;
    ms_write_mask_d = '0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          tag_d = mem_addr_i[31:3];
          hi_d = mem_addr_i[2];
          ms_mem_addr_d = mem_addr_i;
          if (mem_we_i) begin
            ms_write_d = 1'b1;
            ms_write_data_d = mem_wdata_i;
            ms_write_mask_d = mem_sel_i;
            state_d = WRITE;
            if (mem_addr_i[31:3] == buf_tag_q) buf_vld_d = 1'b0;
          end else begin
            ms_mem_req_d = 1'b1;
            state_d = WAIT_MEM;
          end
        end else if (if_req_i) begin
          tag_d = if_addr_i[31:3];
          hi_d = if_addr_i[2];
          if (hit) begin
            if_ack_d = 1'b1;
            if_data_d = if_addr_i[2] ? buf_data_q[63:32] : buf_data_q[31:0];
            state_d = ACK;
          end else begin
            ms_if_req_d = 1'b1;
            ms_if_addr_d = if_addr_i;
            state_d = WAIT_IF;
          end
        end
      end
      WAIT_IF: begin
        cnt_d = cnt_q + 1'b1;
        if (if_ms_rep_i) begin
          cnt_d = '0;
          if_ack_d = 1'b1;
          if_data_d = hi_q ? if_ms_rep_data_i[63:32] : if_ms_rep_data_i[31:0];
          buf_vld_d = 1'b1;
          buf_tag_d = tag_q;
          buf_data_d = if_ms_rep_data_i;
          state_d = ACK;
        end else if (timed_out) begin
          cnt_d = '0;
          if_ack_d = 1'b1;
          err_d = 1'b1;
          state_d = ACK;
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ms_rep_i) begin
          cnt_d = '0;
          mem_ack_d = 1'b1;
          mem_rdata_d = hi_q ? mem_ms_rep_data_i[63:32] : mem_ms_rep_data_i[31:0];
          state_d = ACK;
        end else if (timed_out) begin
          cnt_d = '0;
          mem_ack_d = 1'b1;
          err_d = 1'b1;
          state_d = ACK;
        end
      end
      WRITE: begin
        mem_ack_d = 1'b1;
        state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      hi_q <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
      buf_data_q <= '0;
      if_ack_q <= 1'b0;
      if_data_q <= '0;
      mem_ack_q <= 1'b0;
      mem_rdata_q <= '0;
      err_q <= 1'b0;
      ms_if_req_q <= 1'b0;
      ms_if_addr_q <= '0;
      ms_mem_req_q <= 1'b0;
      ms_mem_addr_q <= '0;
      ms_write_q <= 1'b0;
      ms_write_data_q <= '0;
      ms_write_mask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      hi_q <= hi_d;
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
      buf_data_q <= buf_data_d;
      if_ack_q <= if_ack_d;
      if_data_q <= if_data_d;
      mem_ack_q <= mem_ack_d;
      mem_rdata_q <= mem_rdata_d;
      err_q <= err_d;
      ms_if_req_q <= ms_if_req_d;
      ms_if_addr_q <= ms_if_addr_d;
      ms_mem_req_q <= ms_mem_req_d;
      ms_mem_addr_q <= ms_mem_addr_d;
      ms_write_q <= ms_write_d;
      ms_write_data_q <= ms_write_data_d;
      ms_write_mask_q <= ms_write_mask_d;
    end
  end
  assign if_ack_o = if_ack_q;
  assign if_data_o = if_data_q;
  assign mem_ack_o = mem_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign err_o = err_q;
  assign ms_if_req_o = ms_if_req_q;
  assign ms_if_addr_o = ms_if_addr_q;
  assign ms_mem_req_o = ms_mem_req_q;
  assign ms_mem_addr_o = ms_mem_addr_q;
  assign ms_write_o = ms_write_q;
  assign ms_write_data_o = ms_write_data_q;
  assign ms_write_mask_o = ms_write_mask_q;
endmodule
